// File: rtl/t_chain_counter.sv
// Modulo-MOD up/down counter built from WIDTH T-type stages. It exports the per-bit
// toggle drives and a same-cycle terminal count so downstream T stages and counters can cascade.
module t_chain_counter #(
  parameter int WIDTH = 4,
  parameter int MOD   = 10
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             up_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] count_o,
  output logic [WIDTH-1:0] count_n_o,
  output logic [WIDTH-1:0] t_vec_o,
  output logic             tc_o,
  output logic             wrap_o
);

  if (WIDTH < 1 || WIDTH > 16 || MOD < 2 || MOD > (1 << WIDTH)) begin : gBadParams
    $error("t_chain_counter: illegal WIDTH=%0d / MOD=%0d", WIDTH, MOD);
  end

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MOD - 1);
  localparam logic [WIDTH:0]   ModExt = (WIDTH + 1)'(MOD);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] countN_q;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] loadSat;
  logic [WIDTH-1:0] upChain, downChain;
  logic [WIDTH-1:0] tVec;
  logic             atTopOrAbove, outOfRange, tc;

  assign loadSat      = ({1'b0, load_val_i} >= ModExt) ? MaxVal : load_val_i;
  assign atTopOrAbove = (count_q >= MaxVal);
  assign outOfRange   = ({1'b0, count_q} >= ModExt);
  assign tc           = en_i & (up_i ? (count_q == MaxVal) : (count_q == '0));

  // Stage i toggles when all lower bits are 1 (up) or all 0 (down).
  always_comb begin
    logic [WIDTH-1:0] lowMask;
    upChain   = '0;
    downChain = '0;
    lowMask   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      lowMask      = WIDTH'((1 << i) - 1);
      upChain[i]   = &(count_q | ~lowMask);
      downChain[i] = &(~count_q | ~lowMask);
    end
  end

  // Wrap cycles override the chain so the stages land on 0 (up) or MOD-1 (down).
  always_comb begin
    tVec = '0;
    if (load_i) begin
      tVec = count_q ^ loadSat;
    end else if (en_i) begin
      if (up_i) begin
        tVec = atTopOrAbove ? count_q : upChain;
      end else begin
        tVec = ((count_q == '0) || outOfRange) ? (count_q ^ MaxVal) : downChain;
      end
    end
  end

  assign count_d = count_q ^ tVec;
  assign wrap_d  = en_i & ~load_i & tc;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q  <= '0;
      countN_q <= '1;
      wrap_q   <= 1'b0;
    end else begin
      count_q  <= count_d;
      countN_q <= ~count_d;
      wrap_q   <= wrap_d;
    end
  end

  assign count_o   = count_q;
  assign count_n_o = countN_q;
  assign t_vec_o   = tVec;
  assign tc_o      = tc;
  assign wrap_o    = wrap_q;

endmodule

// File: tb/tb_t_chain_counter.sv
// Drives a decimal (WIDTH=4, MOD=10) and a binary (WIDTH=3, MOD=8) counter in lockstep
// and compares both against an arithmetic model of the counting rules.
module tb_t_chain_counter;

  logic       clk = 1'b0;
  logic       rstN, en, up, load;
  logic [3:0] loadValA;
  logic [2:0] loadValB;
  logic [3:0] countA, countNA, tVecA;
  logic [2:0] countB, countNB, tVecB;
  logic       tcA, wrapA, tcB, wrapB;

  int  vectors = 0;
  int  misses  = 0;
  int  modelA, modelB;
  bit  modelValid = 0;

  always #5 clk = ~clk;

  t_chain_counter #(.WIDTH(4), .MOD(10)) dutA (
    .clk_i(clk), .rst_ni(rstN), .en_i(en), .up_i(up), .load_i(load),
    .load_val_i(loadValA), .count_o(countA), .count_n_o(countNA),
    .t_vec_o(tVecA), .tc_o(tcA), .wrap_o(wrapA)
  );

  t_chain_counter #(.WIDTH(3), .MOD(8)) dutB (
    .clk_i(clk), .rst_ni(rstN), .en_i(en), .up_i(up), .load_i(load),
    .load_val_i(loadValB), .count_o(countB), .count_n_o(countNB),
    .t_vec_o(tVecB), .tc_o(tcB), .wrap_o(wrapB)
  );

  // Next count from the counting rules, ignoring reset.
  function automatic int nextCount(int cur, bit e, bit u, bit l, int lv, int m);
    if (l) return (lv >= m) ? m - 1 : lv;
    if (!e) return cur;
    if (u) return (cur >= m - 1) ? 0 : cur + 1;
    return (cur == 0 || cur >= m) ? m - 1 : cur - 1;
  endfunction

  function automatic bit termCount(int cur, bit e, bit u, int m);
    return e && (u ? (cur == m - 1) : (cur == 0));
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      misses++;
      $display("[TB] FAIL %s: observed %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // One clock: check combinational outputs before the edge, registered outputs after it.
  task automatic applyStimulus(input bit r, input bit e, input bit u, input bit l, input int lv);
    int  nA, nB;
    bit  tcExpA, tcExpB;
    rstN     = r;
    en       = e;
    up       = u;
    load     = l;
    loadValA = 4'(lv);
    loadValB = 3'(lv);
    #1;
    nA     = nextCount(modelA, e, u, l, lv & 15, 10);
    nB     = nextCount(modelB, e, u, l, lv & 7, 8);
    tcExpA = termCount(modelA, e, u, 10);
    tcExpB = termCount(modelB, e, u, 8);
    if (modelValid) begin
      checkOutput("tcA", 32'(tcA), 32'(tcExpA));
      checkOutput("tvecA", 32'(tVecA), modelA ^ nA);
      checkOutput("tcB", 32'(tcB), 32'(tcExpB));
      checkOutput("tvecB", 32'(tVecB), modelB ^ nB);
    end
    @(posedge clk);
    #1;
    if (!r) begin
      modelA     = 0;
      modelB     = 0;
      modelValid = 1;
      checkOutput("wrapA", 32'(wrapA), 0);
      checkOutput("wrapB", 32'(wrapB), 0);
    end else begin
      modelA = nA;
      modelB = nB;
      checkOutput("wrapA", 32'(wrapA), 32'(e && !l && tcExpA));
      checkOutput("wrapB", 32'(wrapB), 32'(e && !l && tcExpB));
    end
    checkOutput("countA", 32'(countA), modelA);
    checkOutput("countNA", 32'(countNA), (~modelA) & 15);
    checkOutput("countB", 32'(countB), modelB);
    checkOutput("countNB", 32'(countNB), (~modelB) & 7);
    @(negedge clk);
  endtask

  initial begin
    rstN = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; loadValA = '0; loadValB = '0;
    modelA = 0; modelB = 0;
    @(negedge clk);

    // Reset dominates en and load
    repeat (2) applyStimulus(0, 1, 1, 1, 5);
    checkOutput("rstCount", 32'(countA), 0);
    checkOutput("rstCountN", 32'(countNA), 15);
    checkOutput("rstTc", 32'(tcA), 0);

    // Up run across the 9 -> 0 wrap
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1, 1, 1, 0, 0);
      if (i == 8) begin
        checkOutput("upAt9", 32'(countA), 9);
        checkOutput("tvecAt9", 32'(tVecA), 9);
        checkOutput("tcAt9", 32'(tcA), 1);
      end
      if (i == 9) checkOutput("wrapAfter9", 32'(wrapA), 1);
    end

    // Down run across the 0 -> 9 borrow
    applyStimulus(1, 0, 1, 1, 2);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 1, 0, 0, 0);
      if (i == 1) begin
        checkOutput("tvecAt0", 32'(tVecA), 9);
        checkOutput("tcAt0", 32'(tcA), 1);
      end
      if (i == 2) checkOutput("borrowWrap", 32'(wrapA), 1);
    end

    // Saturating load, then load with en at the terminal count
    applyStimulus(1, 0, 1, 1, 13);
    checkOutput("loadSat", 32'(countA), 9);
    applyStimulus(1, 1, 1, 1, 3);
    checkOutput("loadWins", 32'(countA), 3);
    checkOutput("loadNoWrap", 32'(wrapA), 0);

    // Hold, then reset coincident with load
    repeat (5) applyStimulus(1, 0, 1, 0, 0);
    applyStimulus(1, 0, 1, 1, 7);
    applyStimulus(0, 1, 1, 1, 4);
    checkOutput("rstOverLoad", 32'(countA), 0);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(15) != 0), ($urandom_range(3) != 0),
                    1'($urandom_range(1)), ($urandom_range(7) == 0),
                    int'($urandom_range(15)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule
